// File: rtl/aes_word_sequencer.sv
// Stream adapter for an iterative 128-bit AES core: gathers 4 key + 4 plaintext words,
// pulses encrypt, waits (bounded) for done, then returns the ciphertext as 4 words.
module aes_word_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         aes_encrypt,
    output logic [127:0] aes_key,
    output logic [127:0] aes_plain_text,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {StLoad, StStart, StWait, StUnload} state_e;

    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e       state_q;
    logic [2:0]   wcnt_q;
    logic [1:0]   ocnt_q;
    logic [CNT_W-1:0] wait_q;
    logic         done_q;
    logic [127:0] result_q;
    logic         timeout_q;
    logic         accept;
    logic         done_rise;

    assign in_ready    = (state_q == StLoad);
    assign accept      = in_valid & in_ready;
    assign done_rise   = aes_done & ~done_q;

    assign aes_encrypt = (state_q == StStart);
    assign busy        = (state_q == StStart) || (state_q == StWait);
    assign out_valid   = (state_q == StUnload);
    assign out_last    = (state_q == StUnload) && (ocnt_q == 2'd3);
    // Big-endian: word 0 is the most significant 32 bits.
    assign out_data    = result_q[{~ocnt_q, 5'd0} +: 32];
    assign timeout_err = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StLoad;
            wcnt_q         <= '0;
            ocnt_q         <= '0;
            wait_q         <= '0;
            done_q         <= 1'b0;
            result_q       <= '0;
            timeout_q      <= 1'b0;
            aes_key        <= '0;
            aes_plain_text <= '0;
        end else begin
            done_q <= aes_done;
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        timeout_q <= 1'b0;
                        if (!wcnt_q[2]) begin
                            aes_key[{~wcnt_q[1:0], 5'd0} +: 32] <= in_data;
                        end else begin
                            aes_plain_text[{~wcnt_q[1:0], 5'd0} +: 32] <= in_data;
                        end
                        // Wraps back to 0 after word 7.
                        wcnt_q <= wcnt_q + 3'd1;
                        if (wcnt_q == 3'd7) begin
                            state_q <= StStart;
                        end
                    end
                end
                StStart: begin
                    wait_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // A rising done beats an expiring counter in the same cycle.
                    if (done_rise) begin
                        result_q <= aes_dout;
                        ocnt_q   <= '0;
                        state_q  <= StUnload;
                    end else if (wait_q == WaitLast) begin
                        timeout_q <= 1'b1;
                        wcnt_q    <= '0;
                        state_q   <= StLoad;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                StUnload: begin
                    if (out_ready) begin
                        ocnt_q <= ocnt_q + 2'd1;
                        if (ocnt_q == 2'd3) begin
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule
